// File: rtl/mem_access_sequencer.sv
// Timed access sequencer for the shared-bus pseudo-SRAM (async mode) and NOR flash.
// One access at a time; CE/strobe windows are counted out by a single reloadable down-counter.
module mem_access_sequencer #(
    parameter int unsigned ADDRESS_SIZE = 24,
    parameter int unsigned DATA_SIZE    = 16,
    parameter int unsigned SETUP_CYC    = 1,
    parameter int unsigned RAM_WAIT     = 4,
    parameter int unsigned ROM_WAIT     = 7,
    parameter int unsigned HOLD_CYC     = 1,
    parameter int unsigned RP_CYC       = 16,
    parameter int unsigned STS_TIMEOUT  = 255
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    req_valid,
    output logic                    req_ready,
    input  logic [ADDRESS_SIZE-1:0] req_addr,
    input  logic [DATA_SIZE-1:0]    req_wdata,
    input  logic [1:0]              req_be,
    input  logic                    req_chip,
    input  logic                    req_we,
    output logic                    rsp_valid,
    output logic [DATA_SIZE-1:0]    rsp_rdata,
    output logic                    rsp_err,
    output logic [ADDRESS_SIZE-1:0] mem_addr,
    input  logic [DATA_SIZE-1:0]    mem_dq_i,
    output logic [DATA_SIZE-1:0]    mem_dq_o,
    output logic                    mem_dq_oe,
    output logic                    mem_lb_n,
    output logic                    mem_ub_n,
    output logic                    mem_oe_n,
    output logic                    mem_we_n,
    output logic                    mt_ce_n,
    output logic                    mt_adv_n,
    output logic                    mt_clk,
    output logic                    mt_cre,
    input  logic                    mt_wait,
    output logic                    st_ce_n,
    output logic                    st_rp_n,
    input  logic                    st_sts
);

    function automatic int unsigned max2(input int unsigned a, input int unsigned b);
        return (a > b) ? a : b;
    endfunction

    localparam int unsigned CntMax = max2(max2(max2(SETUP_CYC, RAM_WAIT), max2(ROM_WAIT, HOLD_CYC)),
                                          max2(RP_CYC, STS_TIMEOUT));
    localparam int unsigned CntW   = $clog2(CntMax + 1);
    localparam int unsigned Half   = DATA_SIZE / 2;

    typedef enum logic [2:0] {
        StRpWait, StIdle, StSetup, StAccess, StHold, StPoll, StResp
    } state_e;

    state_e                  state_q, state_d;
    logic [CntW-1:0]         cnt_q, cnt_d;
    logic [ADDRESS_SIZE-1:0] addr_q;
    logic [DATA_SIZE-1:0]    wdata_q;
    logic [1:0]              be_q;
    logic                    chip_q, we_q;
    logic [DATA_SIZE-1:0]    rdata_q, rdata_d;
    logic                    err_q, err_d;
    logic                    cnt_zero, accept, active;
    logic [DATA_SIZE-1:0]    lane_mask;
    logic                    unused_wait;

    assign unused_wait = mt_wait;
    assign cnt_zero    = (cnt_q == '0);
    assign accept      = (state_q == StIdle) && req_valid;
    assign lane_mask   = {{Half{be_q[1]}}, {Half{be_q[0]}}};

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        rdata_d = rdata_q;
        err_d   = err_q;
        case (state_q)
            StRpWait: begin
                if (cnt_zero) state_d = StIdle;
                else          cnt_d = cnt_q - CntW'(1);
            end
            StIdle: begin
                cnt_d = '0;
                if (req_valid) begin
                    rdata_d = '0;
                    if (req_be == 2'b00) begin
                        // Empty lane mask: complete immediately with error, bus untouched.
                        state_d = StResp;
                        err_d   = 1'b1;
                    end else begin
                        state_d = StSetup;
                        cnt_d   = CntW'(SETUP_CYC - 1);
                        err_d   = 1'b0;
                    end
                end
            end
            StSetup: begin
                if (cnt_zero) begin
                    state_d = StAccess;
                    cnt_d   = chip_q ? CntW'(ROM_WAIT - 1) : CntW'(RAM_WAIT - 1);
                end else begin
                    cnt_d = cnt_q - CntW'(1);
                end
            end
            StAccess: begin
                if (cnt_zero) begin
                    state_d = StHold;
                    cnt_d   = CntW'(HOLD_CYC - 1);
                    if (!we_q) rdata_d = mem_dq_i & lane_mask;
                end else begin
                    cnt_d = cnt_q - CntW'(1);
                end
            end
            StHold: begin
                if (cnt_zero) begin
                    if (chip_q && we_q) begin
                        state_d = StPoll;
                        cnt_d   = CntW'(STS_TIMEOUT - 1);
                    end else begin
                        state_d = StResp;
                        cnt_d   = '0;
                    end
                end else begin
                    cnt_d = cnt_q - CntW'(1);
                end
            end
            StPoll: begin
                if (st_sts) begin
                    state_d = StResp;
                    cnt_d   = '0;
                end else if (cnt_zero) begin
                    state_d = StResp;
                    cnt_d   = '0;
                    err_d   = 1'b1;
                end else begin
                    cnt_d = cnt_q - CntW'(1);
                end
            end
            StResp: begin
                state_d = StIdle;
                cnt_d   = '0;
            end
            default: begin
                state_d = StRpWait;
                cnt_d   = CntW'(RP_CYC - 1);
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StRpWait;
            cnt_q   <= CntW'(RP_CYC - 1);
            addr_q  <= '0;
            wdata_q <= '0;
            be_q    <= '0;
            chip_q  <= 1'b0;
            we_q    <= 1'b0;
            rdata_q <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            rdata_q <= rdata_d;
            err_q   <= err_d;
            if (accept) begin
                addr_q  <= req_addr;
                wdata_q <= req_wdata;
                be_q    <= req_be;
                chip_q  <= req_chip;
                we_q    <= req_we;
            end
        end
    end

    // Bus is owned only from SETUP through HOLD; everything idles at its inactive level otherwise.
    assign active    = (state_q == StSetup) || (state_q == StAccess) || (state_q == StHold);
    assign req_ready = (state_q == StIdle);
    assign rsp_valid = (state_q == StResp);
    assign rsp_rdata = rsp_valid ? rdata_q : '0;
    assign rsp_err   = rsp_valid & err_q;
    assign mem_addr  = active ? addr_q : '0;
    assign mem_dq_oe = active & we_q;
    assign mem_dq_o  = mem_dq_oe ? wdata_q : '0;
    assign mem_lb_n  = ~(active & be_q[0]);
    assign mem_ub_n  = ~(active & be_q[1]);
    assign mem_oe_n  = ~((state_q == StAccess) & ~we_q);
    assign mem_we_n  = ~((state_q == StAccess) & we_q);
    assign mt_ce_n   = ~(active & ~chip_q);
    assign st_ce_n   = ~(active & chip_q);
    assign mt_adv_n  = ~((state_q == StSetup) & ~chip_q);
    assign mt_clk    = 1'b0;
    assign mt_cre    = 1'b0;
    assign st_rp_n   = (state_q != StRpWait);

endmodule

// File: tb/tb_mem_access_sequencer.sv
// Self-checking bench for mem_access_sequencer: table-driven accesses with per-cycle bus checks,
// a response scoreboard, and hand sequences for reset, ROM status polling and abort.
module tb_mem_access_sequencer;

    localparam int unsigned AW = 24, DW = 16;
    localparam int unsigned S = 1, RW = 4, OW = 7, H = 1, RP = 16, TO = 255;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          req_valid = 1'b0, req_ready;
    logic [AW-1:0] req_addr = '0;
    logic [DW-1:0] req_wdata = '0;
    logic [1:0]    req_be = 2'b00;
    logic          req_chip = 1'b0, req_we = 1'b0;
    logic          rsp_valid, rsp_err;
    logic [DW-1:0] rsp_rdata;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_dq_i, mem_dq_o;
    logic          mem_dq_oe, mem_lb_n, mem_ub_n, mem_oe_n, mem_we_n;
    logic          mt_ce_n, mt_adv_n, mt_clk, mt_cre, st_ce_n, st_rp_n;
    logic          mt_wait = 1'b0;
    logic          st_sts = 1'b1;
    logic [DW-1:0] dq_val = '0;

    // Memory model: drives read data only while output enable is low.
    assign mem_dq_i = !mem_oe_n ? dq_val : 16'hDEAD;

    always #5 clk = ~clk;

    mem_access_sequencer #(
        .ADDRESS_SIZE(AW), .DATA_SIZE(DW), .SETUP_CYC(S), .RAM_WAIT(RW), .ROM_WAIT(OW),
        .HOLD_CYC(H), .RP_CYC(RP), .STS_TIMEOUT(TO)
    ) dut (
        .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
        .req_addr(req_addr), .req_wdata(req_wdata), .req_be(req_be), .req_chip(req_chip),
        .req_we(req_we), .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
        .mem_addr(mem_addr), .mem_dq_i(mem_dq_i), .mem_dq_o(mem_dq_o), .mem_dq_oe(mem_dq_oe),
        .mem_lb_n(mem_lb_n), .mem_ub_n(mem_ub_n), .mem_oe_n(mem_oe_n), .mem_we_n(mem_we_n),
        .mt_ce_n(mt_ce_n), .mt_adv_n(mt_adv_n), .mt_clk(mt_clk), .mt_cre(mt_cre),
        .mt_wait(mt_wait), .st_ce_n(st_ce_n), .st_rp_n(st_rp_n), .st_sts(st_sts)
    );

    typedef struct {
        logic          chip;
        logic          we;
        logic [AW-1:0] addr;
        logic [DW-1:0] wdata;
        logic [1:0]    be;
        logic [DW-1:0] dq;
        logic [DW-1:0] exp_rdata;
        logic          exp_err;
        int            exp_lat;
    } vec_t;

    typedef struct {
        logic [DW-1:0] rdata;
        logic          err;
        int            due;
    } exp_t;

    exp_t exp_q[$];
    int   cyc = 0;
    int   checks = 0;
    int   errors = 0;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (rsp_valid === 1'b1) begin
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_rsp: got rsp_valid at cyc %0d, required none", cyc);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                if (rsp_rdata !== e.rdata || rsp_err !== e.err || cyc != e.due) begin
                    errors++;
                    $display("FAIL rsp: got rdata=%h err=%b cyc=%0d, required rdata=%h err=%b cyc=%0d",
                             rsp_rdata, rsp_err, cyc, e.rdata, e.err, e.due);
                end
            end
        end
    end

    function automatic vec_t mk(input logic chip, input logic we, input logic [AW-1:0] addr,
                                input logic [DW-1:0] wdata, input logic [1:0] be,
                                input logic [DW-1:0] dq, input logic [DW-1:0] exp_rdata,
                                input logic exp_err, input int exp_lat);
        vec_t v;
        v.chip = chip; v.we = we; v.addr = addr; v.wdata = wdata; v.be = be; v.dq = dq;
        v.exp_rdata = exp_rdata; v.exp_err = exp_err; v.exp_lat = exp_lat;
        return v;
    endfunction

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s: got %h, required %h", name, got, want);
        end
    endtask

    // Waits for ready, presents the request for one edge, then scrambles the inputs.
    task automatic issue(input vec_t v, output int acc, output bit ok);
        ok = 1'b1;
        acc = 0;
        if (exp_q.size() != 0) begin
            checks++; errors++;
            $display("FAIL missing_rsp: got %0d pending responses, required 0", exp_q.size());
            exp_q.delete();
        end
        for (int n = 0; n < 50 && req_ready !== 1'b1; n++) @(negedge clk);
        if (req_ready !== 1'b1) begin
            checks++; errors++;
            $display("FAIL ready_timeout: got req_ready=%b, required 1", req_ready);
            ok = 1'b0;
            return;
        end
        dq_val    = v.dq;
        req_valid = 1'b1;
        req_addr  = v.addr;
        req_wdata = v.wdata;
        req_be    = v.be;
        req_chip  = v.chip;
        req_we    = v.we;
        @(posedge clk);
        #1;
        acc       = cyc;
        req_valid = 1'b0;
        req_addr  = ~req_addr;
        req_wdata = ~req_wdata;
        req_be    = ~req_be;
        req_chip  = ~req_chip;
        req_we    = ~req_we;
    endtask

    task automatic wait_rsp(input int budget);
        int n;
        for (n = 0; n < budget && exp_q.size() != 0; n++) @(negedge clk);
        if (exp_q.size() != 0) begin
            checks++; errors++;
            $display("FAIL rsp_timeout: got no response in %0d cycles, required one", budget);
            exp_q.delete();
        end
    endtask

    // Runs one access and checks every bus signal in each cycle against the spec windows.
    task automatic run_vec(input vec_t v);
        int acc;
        bit ok;
        exp_t e;
        issue(v, acc, ok);
        if (!ok) return;
        e.rdata = v.exp_rdata;
        e.err   = v.exp_err;
        e.due   = acc + v.exp_lat - 1;
        exp_q.push_back(e);
        for (int k = 1; k <= v.exp_lat + 1; k++) begin
            int  w;
            bit  in_c, acc_ph;
            logic [8:0]    want_c, got_c;
            logic [AW-1:0] want_a;
            logic [DW-1:0] want_d;
            @(negedge clk);
            w      = v.chip ? OW : RW;
            in_c   = (v.be != 2'b00) && k <= S + w + H;
            acc_ph = in_c && k > S && k <= S + w;
            want_c = {!(in_c && !v.chip), !(in_c && v.chip), !(in_c && !v.chip && k <= S),
                      !(acc_ph && !v.we), !(acc_ph && v.we), in_c && v.we,
                      !(in_c && v.be[0]), !(in_c && v.be[1]), k == v.exp_lat + 1};
            got_c  = {mt_ce_n, st_ce_n, mt_adv_n, mem_oe_n, mem_we_n, mem_dq_oe,
                      mem_lb_n, mem_ub_n, req_ready};
            want_a = in_c ? v.addr : '0;
            want_d = (in_c && v.we) ? v.wdata : '0;
            check($sformatf("bus_cycle%0d", k), {15'd0, got_c, mem_addr, mem_dq_o},
                  {15'd0, want_c, want_a, want_d});
        end
    endtask

    vec_t tbl[8];

    initial begin
        int  acc;
        bit  ok;
        bit  seen;
        exp_t e;
        vec_t v;

        #500000;
        $display("FAIL watchdog: got simulation time limit, required completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int   acc;
        bit   ok;
        bit   seen;
        exp_t e;
        vec_t v;

        tbl[0] = mk(1'b0, 1'b0, 24'h000123, 16'h0000, 2'b11, 16'hBEEF, 16'hBEEF, 1'b0, 7);
        tbl[1] = mk(1'b0, 1'b0, 24'h0ABCDE, 16'h0000, 2'b01, 16'h1234, 16'h0034, 1'b0, 7);
        tbl[2] = mk(1'b0, 1'b0, 24'h000FFF, 16'h0000, 2'b10, 16'h1234, 16'h1200, 1'b0, 7);
        tbl[3] = mk(1'b0, 1'b1, 24'h000456, 16'hA55A, 2'b10, 16'h0000, 16'h0000, 1'b0, 7);
        tbl[4] = mk(1'b1, 1'b0, 24'hFFFFFF, 16'h0000, 2'b11, 16'hCAFE, 16'hCAFE, 1'b0, 10);
        tbl[5] = mk(1'b1, 1'b1, 24'h800001, 16'h5AA5, 2'b01, 16'h0000, 16'h0000, 1'b0, 11);
        tbl[6] = mk(1'b0, 1'b0, 24'h000010, 16'h0000, 2'b00, 16'hFFFF, 16'h0000, 1'b1, 1);
        tbl[7] = mk(1'b1, 1'b1, 24'h000020, 16'h1111, 2'b00, 16'h0000, 16'h0000, 1'b1, 1);

        // Reset values and ROM reset-power-down release timing.
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("reset_ctrl",
              {50'd0, req_ready, rsp_valid, rsp_err, mem_dq_oe, mem_lb_n, mem_ub_n, mem_oe_n,
               mem_we_n, mt_ce_n, mt_adv_n, mt_clk, mt_cre, st_ce_n, st_rp_n},
              {50'd0, 14'b0000_1111_1100_10});
        check("reset_data", {16'd0, rsp_rdata, mem_addr, mem_dq_o}, 64'd0);
        rst = 1'b0;
        repeat (RP - 1) @(negedge clk);
        check("rp_low_before", {62'd0, st_rp_n, req_ready}, 64'd0);
        @(negedge clk);
        check("rp_release", {62'd0, st_rp_n, req_ready}, {62'd0, 2'b11});

        for (int i = 0; i < 8; i++) run_vec(tbl[i]);

        // ROM write: status busy for 20 poll cycles, then ready.
        st_sts = 1'b0;
        v = mk(1'b1, 1'b1, 24'h000777, 16'h1357, 2'b11, 16'h0000, 16'h0000, 1'b0, 0);
        issue(v, acc, ok);
        if (ok) begin
            e.rdata = '0; e.err = 1'b0; e.due = acc + 30;
            exp_q.push_back(e);
            while (cyc < acc + 29) @(negedge clk);
            st_sts = 1'b1;
            wait_rsp(50);
        end

        // ROM write: status never goes ready, so the poll times out.
        st_sts = 1'b0;
        v = mk(1'b1, 1'b1, 24'h000778, 16'h2468, 2'b11, 16'h0000, 16'h0000, 1'b0, 0);
        issue(v, acc, ok);
        if (ok) begin
            e.rdata = '0; e.err = 1'b1; e.due = acc + 264;
            exp_q.push_back(e);
            wait_rsp(400);
        end
        st_sts = 1'b1;

        // Reset during the strobe window of a ROM read aborts with no response.
        v = mk(1'b1, 1'b0, 24'h00ABCD, 16'h0000, 2'b11, 16'h9999, 16'h0000, 1'b0, 0);
        issue(v, acc, ok);
        if (ok) begin
            while (cyc < acc + 3) @(negedge clk);
            check("abort_in_access", {63'd0, mem_oe_n}, 64'd0);
            rst = 1'b1;
            @(negedge clk);
            check("abort_strobes",
                  {57'd0, mem_oe_n, mem_we_n, st_ce_n, mt_ce_n, rsp_valid, st_rp_n, req_ready},
                  {57'd0, 7'b1111000});
            rst  = 1'b0;
            seen = 1'b0;
            repeat (RP - 1) begin
                @(negedge clk);
                if (req_ready !== 1'b0 || rsp_valid !== 1'b0 || st_rp_n !== 1'b0) seen = 1'b1;
            end
            check("abort_rp_wait", {63'd0, seen}, 64'd0);
            @(negedge clk);
            check("abort_recover", {62'd0, st_rp_n, req_ready}, {62'd0, 2'b11});
        end

        run_vec(tbl[0]);
        repeat (2) @(negedge clk);
        if (exp_q.size() != 0) begin
            checks++; errors++;
            $display("FAIL final_pending: got %0d pending responses, required 0", exp_q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
